// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one registered FP compare stage (feq/flt/fle)
// among NREQ requesters, with a 1-entry response register per port.
module fcmp_sched #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_x1,
  input  logic [32*NREQ-1:0]   req_x2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_data,
  output logic [NREQ-1:0]      rsp_err,
  output logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshakes: a request transfers when req_valid[i] & req_ready[i]; a response
  // transfers when rsp_valid[i] & rsp_ready[i], and holds its data until then.

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            iss_vld_q;
  logic [PW-1:0]   iss_port_q;
  logic [1:0]      iss_op_q;
  logic [2:0]      unit_q, unit_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_flag_q, rsp_err_q;

  logic [NREQ-1:0] inflight, eligible, grant;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [1:0]      sel_op;
  logic [31:0]     sel_x1, sel_x2;
  logic            res_flag;

  // Returns {fle, flt, feq}; zeros and denormals compare as zero, NaN gives all 0.
  function automatic logic [2:0] fp_cmp(input logic [31:0] a, input logic [31:0] b);
    logic        a_zero, b_zero, a_nan, b_nan, sa, sb, eq, lt;
    logic [30:0] ma, mb;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    ma     = a_zero ? 31'h0 : a[30:0];
    mb     = b_zero ? 31'h0 : b[30:0];
    sa     = a[31] & ~a_zero;
    sb     = b[31] & ~b_zero;
    eq     = (sa == sb) && (ma == mb);
    if (sa != sb)  lt = sa;
    else if (sa)   lt = (ma > mb);
    else           lt = (ma < mb);
    if (a_nan || b_nan) begin
      eq = 1'b0;
      lt = 1'b0;
    end
    return {lt | eq, lt, eq};
  endfunction

  always_comb begin
    inflight = '0;
    if (iss_vld_q) inflight[iss_port_q] = 1'b1;
  end

  assign eligible = req_valid & ~inflight & (~rsp_valid_q | rsp_ready);

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sel_op  = 2'b00;
    sel_x1  = 32'h0;
    sel_x2  = 32'h0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && eligible[idx]) begin
        grant[idx] = 1'b1;
        gnt_any    = 1'b1;
        gnt_idx    = PW'(idx);
        sel_op     = req_op[2*idx +: 2];
        sel_x1     = req_x1[32*idx +: 32];
        sel_x2     = req_x2[32*idx +: 32];
      end
    end
    if (!rstn) begin
      grant   = '0;
      gnt_any = 1'b0;
    end
  end

  assign req_ready = grant;
  assign unit_d    = fp_cmp(sel_x1, sel_x2);
  assign ptr_d     = !gnt_any ? ptr_q :
                     (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign res_flag  = (iss_op_q == 2'b11) ? 1'b0 : unit_q[iss_op_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= '0;
      iss_vld_q   <= 1'b0;
      iss_port_q  <= '0;
      iss_op_q    <= 2'b00;
      unit_q      <= 3'b000;
      rsp_valid_q <= '0;
      rsp_flag_q  <= '0;
      rsp_err_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      iss_vld_q <= gnt_any;
      if (gnt_any) begin
        iss_port_q <= gnt_idx;
        iss_op_q   <= sel_op;
        unit_q     <= unit_d;
      end
      // The inflight guard keeps a write and a drain from hitting the same slot.
      for (int i = 0; i < NREQ; i++) begin
        if (iss_vld_q && (iss_port_q == PW'(i))) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_flag_q[i]  <= res_flag;
          rsp_err_q[i]   <= (iss_op_q == 2'b11);
        end else if (rsp_valid_q[i] && rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp
    assign rsp_data[32*i +: 32] = {31'b0, rsp_flag_q[i]};
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = iss_vld_q | (|rsp_valid_q);

endmodule

// File: tb/tb_fcmp_sched.sv
// Bench for fcmp_sched (NREQ=4): directed vectors, a transaction-level model
// checked every cycle, and literal expectations for the key scenarios.
module tb_fcmp_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [2*N-1:0]  req_op;
  logic [32*N-1:0] req_x1, req_x2, rsp_data;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  fcmp_sched #(.NREQ(N)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference compare on real numbers; denormals flushed to zero.
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'h00) return 0.0;
    d = {x[31], (x[30:23] == 8'hFF) ? 11'h7FF : ({3'b000, x[30:23]} + 11'd896),
         x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [1:0] ref_cmp(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    real ra, rb;
    ra = to_real(a);
    rb = to_real(b);
    case (op)
      2'b00:   return {1'b0, ra == rb};
      2'b01:   return {1'b0, ra < rb};
      2'b10:   return {1'b0, ra <= rb};
      default: return 2'b10;
    endcase
  endfunction

  // Model: accepted requests wait in pend_q until their due cycle, then fill the slot.
  typedef struct {
    int   port;
    logic flag;
    logic err;
    int   due;
  } pend_t;

  pend_t        pend_q[$];
  logic [N-1:0] m_rv;
  logic         m_rd[N];
  logic         m_re[N];
  int           m_ptr;

  always @(negedge clk) begin : model_blk
    logic [N-1:0] infl, elig, g;
    logic [1:0]   r;
    int           gi;
    cyc++;
    if (!rstn) begin
      pend_q.delete();
      m_rv  = '0;
      m_ptr = 0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      for (int j = pend_q.size() - 1; j >= 0; j--) begin
        if (pend_q[j].due == cyc) begin
          m_rv[pend_q[j].port] = 1'b1;
          m_rd[pend_q[j].port] = pend_q[j].flag;
          m_re[pend_q[j].port] = pend_q[j].err;
          pend_q.delete(j);
        end
      end
      infl = '0;
      foreach (pend_q[j]) infl[pend_q[j].port] = 1'b1;
      elig = req_valid & ~infl & (~m_rv | rsp_ready);
      gi = -1;
      for (int k = 0; k < N; k++)
        if (gi < 0 && elig[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
      g = '0;
      if (gi >= 0) g[gi] = 1'b1;
      chk("req_ready", req_ready, g);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("busy", busy, (pend_q.size() != 0 || m_rv != 0) ? 1 : 0);
      for (int p = 0; p < N; p++) begin
        if (m_rv[p]) begin
          chk("rsp_data", rsp_data[32*p +: 32], {31'b0, m_rd[p]});
          chk("rsp_err", rsp_err[p], m_re[p]);
        end
      end
      for (int p = 0; p < N; p++)
        if (m_rv[p] && rsp_ready[p]) m_rv[p] = 1'b0;
      if (gi >= 0) begin
        r = ref_cmp(req_op[2*gi +: 2], req_x1[32*gi +: 32], req_x2[32*gi +: 32]);
        pend_q.push_back('{port: gi, flag: r[0], err: r[1], due: cyc + 2});
        m_ptr = (gi + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_valid[p]       = 1'b1;
    req_op[2*p +: 2]   = op;
    req_x1[32*p +: 32] = a;
    req_x2[32*p +: 32] = b;
  endtask

  task automatic drop(input int p);
    req_valid[p] = 1'b0;
  endtask

  logic [N-1:0] exp_q[$];
  logic [31:0]  vals[8] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000,
                            32'h00000001, 32'h40400000, 32'h7F800000, 32'hFF800000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_x1    = '0;
    req_x2    = '0;
    rsp_ready = '1;
    mid();
    chk("reset_rsp_data", rsp_data[31:0] | rsp_data[63:32] | rsp_data[95:64] | rsp_data[127:96], 0);
    chk("reset_rsp_err", rsp_err, 0);
    tick();
    rstn = 1'b1;
    tick();

    // 1: flt -1 < 1
    set_req(0, 2'b01, 32'hBF800000, 32'h3F800000);
    mid(); chk("t1_ready", req_ready, 4'b0001);
    tick(); drop(0);
    mid(); chk("t1_busy", busy, 1); chk("t1_rv_early", rsp_valid[0], 0);
    tick();
    mid(); chk("t1_rv", rsp_valid[0], 1); chk("t1_data", rsp_data[31:0], 1);
    chk("t1_err", rsp_err[0], 0);
    tick();
    mid(); chk("t1_idle", busy, 0);

    // 2: simultaneous fle 3,3 on ports 0/1 after reset
    tick(); rstn = 1'b0;
    tick(); rstn = 1'b1;
    tick();
    set_req(0, 2'b10, 32'h40400000, 32'h40400000);
    set_req(1, 2'b10, 32'h40400000, 32'h40400000);
    mid(); chk("t2_gnt0", req_ready, 4'b0001);
    tick(); drop(0);
    mid(); chk("t2_gnt1", req_ready, 4'b0010);
    tick(); drop(1);
    mid(); chk("t2_rv0", rsp_valid[1:0], 2'b01); chk("t2_d0", rsp_data[31:0], 1);
    tick();
    mid(); chk("t2_rv1", rsp_valid[1:0], 2'b10); chk("t2_d1", rsp_data[63:32], 1);

    // 3: port0 blocked by an undrained response
    tick();
    rsp_ready[0] = 1'b0;
    set_req(0, 2'b01, 32'h3F800000, 32'h40000000);
    mid(); chk("t3_gnt0", req_ready, 4'b0001);
    tick(); drop(0);
    tick();
    set_req(0, 2'b00, 32'h00000000, 32'h00000000);
    set_req(1, 2'b01, 32'h40000000, 32'h3F800000);
    mid(); chk("t3_gnt1", req_ready, 4'b0010); chk("t3_rv0", rsp_valid[0], 1);
    tick(); drop(1);
    mid(); chk("t3_blocked", req_ready, 4'b0000); chk("t3_hold", rsp_data[31:0], 1);
    tick(); rsp_ready[0] = 1'b1;
    mid(); chk("t3_drain_accept", req_ready, 4'b0001);
    tick(); drop(0);
    mid(); chk("t3_rv0_clear", rsp_valid[0], 0);
    tick();
    mid(); chk("t3_rv0_new", rsp_valid[0], 1); chk("t3_feq00", rsp_data[31:0], 1);

    // 4: feq +0,-0 then illegal op on port1
    tick();
    set_req(1, 2'b00, 32'h00000000, 32'h80000000);
    mid(); chk("t4_gnt", req_ready, 4'b0010);
    tick(); set_req(1, 2'b11, 32'h3F800000, 32'h3F800000);
    mid(); chk("t4_inflight", req_ready, 4'b0000);
    tick();
    mid(); chk("t4_gnt2", req_ready, 4'b0010); chk("t4_feq", rsp_data[63:32], 1);
    chk("t4_err0", rsp_err[1], 0);
    tick(); drop(1);
    tick();
    mid(); chk("t4_rv", rsp_valid[1], 1); chk("t4_ill_data", rsp_data[63:32], 0);
    chk("t4_ill_err", rsp_err[1], 1);

    // 5: reset in the cycle after an issue drops the result
    tick();
    set_req(2, 2'b01, 32'hBF800000, 32'h3F800000);
    mid(); chk("t5_gnt", req_ready, 4'b0100);
    tick(); drop(2); rstn = 1'b0; set_req(1, 2'b00, 32'h0, 32'h0);
    mid(); chk("t5_rv", rsp_valid, 0); chk("t5_busy", busy, 0);
    chk("t5_ready_rst", req_ready, 0);
    tick(); rstn = 1'b1; drop(1);
    mid(); chk("t5_no_rsp_a", rsp_valid, 0); chk("t5_busy_a", busy, 0);
    tick();
    mid(); chk("t5_no_rsp_b", rsp_valid, 0);
    tick();
    set_req(0, 2'b00, 32'h3F800000, 32'h3F800000);
    set_req(3, 2'b00, 32'h3F800000, 32'h3F800000);
    mid(); chk("t5_ptr_reset", req_ready, 4'b0001);
    tick(); drop(0);
    mid(); chk("t5_next", req_ready, 4'b1000);
    tick(); drop(3);
    tick(); tick();

    // 6: all ports requesting continuously
    for (int k = 0; k < 16; k++) exp_q.push_back(N'(1) << (k % N));
    for (int p = 0; p < N; p++) set_req(p, 2'(p), vals[p], vals[(p + 1) % 8]);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin
        int p;
        p = (k - 1) % N;
        set_req(p, 2'((k + p) % 4), vals[(k + p) % 8], vals[(k * 3 + p + 1) % 8]);
      end
      mid(); chk("t6_grant", req_ready, exp_q.pop_front());
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    mid(); chk("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
